// File: rtl/if_prefetch.sv
// Purpose : instruction-fetch front end; sequential fetches into a DEPTH-entry prefetch queue feeding ID.
// Latency : fetch issue to inst_valid_o 2 cycles; redirect to first target instruction valid 3 cycles.
// Backpr. : id_ready_i low lets the queue fill to DEPTH, then fetching stops; it resumes in the cycle a pop occurs.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-low reset
//   imem_ce_o / imem_addr_o       fetch request and address to a one-cycle-latency synchronous memory
//   imem_rdata_i                  read data, valid the cycle after a request
//   redirect_i / redirect_pc_i    taken branch/jump: flush queue, drop in-flight fetch, refetch at target
//   id_ready_i                    ID consumes the head entry this cycle
//   inst_valid_o/inst_o/inst_addr_o  registered head entry of the queue
//   count_o                       occupied entries, 0..DEPTH
module if_prefetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    INST_STEP  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    output logic                    imem_ce_o,
    output logic [ADDR_WIDTH-1:0]   imem_addr_o,
    input  logic [DATA_WIDTH-1:0]   imem_rdata_i,
    input  logic                    redirect_i,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc_i,
    input  logic                    id_ready_i,
    output logic                    inst_valid_o,
    output logic [DATA_WIDTH-1:0]   inst_o,
    output logic [ADDR_WIDTH-1:0]   inst_addr_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_OCC = (CNT_W + 1)'(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] inst;
        logic [ADDR_WIDTH-1:0] addr;
    } entry_t;

    entry_t                  queue_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   fetch_pc_q;
    logic [ADDR_WIDTH-1:0]   inflight_addr_q;
    logic                    inflight_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [CNT_W-1:0]        count_q;

    logic                    pop;
    logic                    issue;
    logic                    wr_en;
    logic [CNT_W:0]          occ;

    // Targets are word aligned; the low two bits of the redirect PC are dropped.
    logic                    redirect_lsb_unused;
    assign redirect_lsb_unused = ^redirect_pc_i[1:0];

    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o & id_ready_i & ~redirect_i;

    // Occupancy seen by the issue rule counts the in-flight fetch as already
    // holding a slot, and credits a slot freed by this cycle's pop so fetching
    // restarts in the same cycle ID drains a full queue. pop implies count_q>=1,
    // so the subtraction cannot underflow.
    assign occ   = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
    // rst_i gates the request so imem_ce_o is low for the whole reset window.
    assign issue = rst_i & ~redirect_i & (occ < DEPTH_OCC);
    assign wr_en = inflight_q & ~redirect_i;

    assign imem_ce_o   = issue;
    assign imem_addr_o = fetch_pc_q;
    assign inst_o      = queue_q[rd_ptr_q].inst;
    assign inst_addr_o = queue_q[rd_ptr_q].addr;
    assign count_o     = count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q      <= RESET_PC;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
        end else if (redirect_i) begin
            // Flush wins over everything; clearing inflight_q discards the
            // response that lands next cycle.
            fetch_pc_q <= {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            if (issue) begin
                fetch_pc_q      <= fetch_pc_q + ADDR_WIDTH'(INST_STEP);
                inflight_addr_q <= fetch_pc_q;
            end
            inflight_q <= issue;
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Storage is cleared on reset so the head outputs read zero while idle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) queue_q[i] <= '0;
        end else if (wr_en) begin
            queue_q[wr_ptr_q] <= '{inst: imem_rdata_i, addr: inflight_addr_q};
        end
    end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Parametrised instruction-fetch front end that replaces the fixed pc_reg + single-entry IF/ID path with a DEPTH-entry prefetch queue.
- Drives a synchronous instruction memory (one-cycle read latency) and issues sequential fetches whenever queue space allows.
- Presents instructions to ID with a valid/ready handshake.
- Supports pipeline stalls (ready low) and branch/jump redirects that flush the queue and discard an in-flight fetch.

Parameters:
ADDR_WIDTH, 32, PC/instruction address width.
DATA_WIDTH, 32, instruction width.
DEPTH, 4, queue entries; power of two, >=2.
RESET_PC, 32'h0000_0000, first fetch address after reset.
INST_STEP, 4, byte increment between sequential fetches.

Ports:
clk_i  in  1  clock, all state updates on rising edge.
rst_i  in  1  reset, asynchronous, active-low.
imem_ce_o  out  1  fetch request; memory samples imem_addr_o on the same edge.
imem_addr_o  out  ADDR_WIDTH  fetch address (= current fetch PC).
imem_rdata_i  in  DATA_WIDTH  read data, valid the cycle after a request.
redirect_i  in  1  branch/jump taken: flush and refetch.
redirect_pc_i  in  ADDR_WIDTH  redirect target.
id_ready_i  in  1  ID accepts head entry this cycle.
inst_valid_o  out  1  head entry valid.
inst_o  out  DATA_WIDTH  head instruction.
inst_addr_o  out  ADDR_WIDTH  head instruction address.
count_o  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

Behaviour:
- State:
  - fetch_pc
  - inflight bit: request issued last cycle, data due now
  - inflight_addr
  - circular buffer: DEPTH x {inst, addr}, with rd_ptr, wr_ptr and count.
- Reset (rst_i low, asynchronous):
  - fetch_pc=RESET_PC; inflight=0; count=0; pointers=0.
  - Outputs: imem_ce_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_addr_o=0, count_o=0.
  - Asserting reset mid-operation drops all queued and in-flight data immediately.
- Output generation:
  - pop = inst_valid_o & id_ready_i & ~redirect_i.
  - inst_valid_o = (count!=0); inst_o/inst_addr_o = entry[rd_ptr]. These are registered storage, not a bypass from imem_rdata_i.
- Issue condition (combinational):
  - issue = ~redirect_i & (count + inflight - pop < DEPTH).
  - imem_ce_o = issue; imem_addr_o = fetch_pc.
  - On issue: fetch_pc += INST_STEP (wraps modulo 2^ADDR_WIDTH); inflight<=1; inflight_addr<=fetch_pc. Otherwise inflight<=0.
- Response:
  - If inflight & ~redirect_i: write {imem_rdata_i, inflight_addr} at wr_ptr; wr_ptr++.
  - Pointers wrap modulo DEPTH.
- Count update: count += write - pop. Simultaneous write and pop on a full or empty queue is legal; the issue rule guarantees no overflow.
- Redirect (priority over everything):
  - count<=0; rd_ptr<=wr_ptr<=0; inflight<=0, so the response arriving next cycle is ignored.
  - fetch_pc<=redirect_pc_i with bits [1:0] forced to 0.
  - No issue and no pop in the redirect cycle. The first fetch at the target goes out the following cycle.
- Latency and throughput:
  - Fetch issue to inst_valid_o is 2 cycles.
  - Redirect to target valid is 3 cycles.
  - Sustained throughput is 1 instruction/cycle while id_ready_i=1.
- Stalls: with id_ready_i=0 the queue fills to DEPTH, then imem_ce_o deasserts. The head entry holds stable. Fetching resumes in the same cycle a pop occurs.
- Empty queue: inst_valid_o=0; id_ready_i is ignored.

Test Plan:
1. Release reset, id_ready_i=1:
   - imem_addr_o = 0x0,0x4,0x8,... with one request per cycle.
   - inst_valid_o rises 2 cycles after the first request; inst_addr_o = 0x0,0x4,... on consecutive cycles, with inst_o matching the memory image.
2. DEPTH=4, id_ready_i=0 from reset:
   - Exactly 4 requests (0x0-0xC) are issued, then imem_ce_o=0 and count_o=4.
   - The head holds 0x0.
   - After raising id_ready_i, pops 0x0,0x4,... continue with no bubble, and fetch resumes at 0x10.
3. Redirect to 0x100 while a request for 0x8 is in flight and 2 entries are queued:
   - The 0x8 data is discarded and count_o=0 the next cycle.
   - The next valid inst_addr_o is 0x100, 3 cycles after the redirect.
4. Redirect and id_ready_i=1 in the same cycle with a valid head: no pop is counted, the queue flushes, and the target 0x200 is delivered next.
5. Redirect with redirect_pc_i=0x103: the fetch address is 0x100.
6. Assert rst_i low asynchronously mid-stream with a full queue: outputs reach reset values before the next clock edge, and after release fetching restarts at RESET_PC.
